// File: rtl/bzone_discrete_sound.sv
// bzone_discrete_sound: Battlezone discrete voices (explosion, shell, engine) mixed with POKEY audio.
// Define BZ_ENGINE_SND_EN to build the engine square-wave voice; without it the engine term is 0 and ctrl[4] is ignored.
module bzone_discrete_sound #(
   parameter int SAMPLE_DIV  = 1000,
   parameter int EXPLO_DECAY = 96,
   parameter int SHELL_DECAY = 24,
   parameter int ENG_LO      = 40,
   parameter int ENG_HI      = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       noise_en,
   input  logic [7:0] ctrl,
   input  logic [3:0] pokey_aud,
   output logic [7:0] sample_out,
   output logic       sample_valid
);
   localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
   localparam logic [15:0] EX_LAST  = 16'(EXPLO_DECAY - 1);
   localparam logic [15:0] SH_LAST  = 16'(SHELL_DECAY - 1);
   logic             en, tick;
   logic [15:0]      cnt_q, cnt_d, lfsr_q, lfsr_d;
   logic [1:0]       noise_q, noise_d, prev_q, trig, step, loud_q, loud_d;
   logic [1:0][7:0]  env_q, env_d;
   logic [1:0][15:0] pre_q, pre_d;
   logic [1:0][5:0]  amp;
   logic [7:0]       eng_amp, mix;
   logic             unused_ok;
   assign en  = ctrl[5];
   assign mix = {2'b00, pokey_aud, 2'b00} + {2'b00, amp[0]} + {2'b00, amp[1]} + eng_amp;
   // sample-rate divider: tick on the last count, then wrap
   always_comb begin
      tick  = cnt_q == DIV_LAST;
      cnt_d = tick ? '0 : cnt_q + 16'd1;
   end
   // noise LFSR (held clear while sound is disabled) and the two noise flops it toggles
   always_comb begin
      lfsr_d  = !en ? '0 : noise_en ? {lfsr_q[14:0], ~(lfsr_q[3] ^ lfsr_q[14])} : lfsr_q;
      noise_d = noise_en ? noise_q ^ {lfsr_q[14:11] != 4'hF, lfsr_q[15]} : noise_q;
   end
   // envelopes: index 0 explosion, 1 shell; trigger edge reloads and beats a coincident decay step
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         trig[i]   = ctrl[2*i+1] & ~prev_q[i];
         step[i]   = tick && pre_q[i] == (i == 0 ? EX_LAST : SH_LAST);
         env_d[i]  = !en ? '0 : trig[i] ? 8'hFF : (step[i] && env_q[i] != '0) ? env_q[i] - 8'd1 : env_q[i];
         pre_d[i]  = (!en || trig[i] || step[i]) ? '0 : tick ? pre_q[i] + 16'd1 : pre_q[i];
         loud_d[i] = (en && trig[i]) ? ctrl[2*i] : loud_q[i];
         amp[i]    = !(en && noise_q[i]) ? '0 : loud_q[i] ? env_q[i][7:2] : {1'b0, env_q[i][7:3]};
      end
   end
   // core state and the output sample, loaded one clk after each tick
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         lfsr_q       <= '0;
         noise_q      <= '0;
         prev_q       <= 2'b11;
         env_q        <= '0;
         pre_q        <= '0;
         loud_q       <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         lfsr_q       <= lfsr_d;
         noise_q      <= noise_d;
         prev_q       <= {ctrl[3], ctrl[1]};
         env_q        <= env_d;
         pre_q        <= pre_d;
         loud_q       <= loud_d;
         sample_out   <= tick ? mix : sample_out;
         sample_valid <= tick;
      end
   end
`ifdef BZ_ENGINE_SND_EN
   logic [15:0] eng_q, eng_d, per_q, per_d, per;
   assign unused_ok = ^ctrl[7:6];
   // engine square wave: period picked while the counter sits at 0, high for its first half
   always_comb begin
      per     = eng_q == '0 ? (ctrl[4] ? 16'(ENG_HI) : 16'(ENG_LO)) : per_q;
      per_d   = per;
      eng_amp = (en && eng_q < (per >> 1)) ? 8'd32 : 8'd0;
      eng_d   = !en ? '0 : !tick ? eng_q : (eng_q == per - 16'd1) ? '0 : eng_q + 16'd1;
   end
   // engine counter and latched period
   always_ff @(posedge clk) begin
      if (rst) begin
         eng_q <= '0;
         per_q <= 16'(ENG_LO);
      end else begin
         eng_q <= eng_d;
         per_q <= per_d;
      end
   end
`else
   assign unused_ok = ^{ctrl[7:6], ctrl[4]};
   assign eng_amp   = 8'd0;
`endif
endmodule
